// File: rtl/alu_status_stage.sv
// alu_status_stage
// Registered ALU stage that sits after the barrel shifter. The stage computes
// add / sub / AND / NOT-B on ain and bin, then registers the result together
// with the Z, N and V status flags. Both sides use a valid/ready handshake.
//
// Optional feature: define ALU_SKID_EN to add a second (skid) entry.
// With the skid entry, in_ready comes from a register, so there is no
// combinational path from out_ready to in_ready. Without it, the stage has a
// single head register and in_ready = !out_valid || out_ready.
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   flush                 synchronous discard of all buffered results
//   in_valid/in_ready     upstream handshake for ain, bin, aluop
//   ain, bin [WIDTH]      operand A (A register), operand B (shifter)
//   aluop [2]             00 add, 01 sub (A-B), 10 AND, 11 NOT B
//   out_valid/out_ready   downstream handshake for c_out and the flags
//   c_out [WIDTH]         result
//   z_out, n_out, v_out   zero, negative, signed overflow
//   ops_done [16]         number of output handshakes, wraps at 2^16
module alu_status_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  input  logic [1:0]       aluop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c_out,
  output logic             z_out,
  output logic             n_out,
  output logic             v_out,
  output logic [15:0]      ops_done
);

  localparam int MSB = WIDTH - 1;

  // Each entry is stored as {v, n, z, result}.
  typedef logic [WIDTH+2:0] entry_t;

  logic [WIDTH-1:0] res;
  logic             res_v;
  entry_t           new_entry;
  entry_t           head_q;
  logic             head_valid;
  logic             accept;
  logic             consume;

  always_comb begin
    res   = '0;
    res_v = 1'b0;
    case (aluop)
      2'b00: begin
        res   = ain + bin;
        res_v = (ain[MSB] == bin[MSB]) && (res[MSB] != ain[MSB]);
      end
      2'b01: begin
        res   = ain + ~bin + WIDTH'(1);
        res_v = (ain[MSB] != bin[MSB]) && (res[MSB] != ain[MSB]);
      end
      2'b10: res = ain & bin;
      default: res = ~bin;
    endcase
    new_entry = {res_v, res[MSB], (res == '0), res};
  end

  assign consume   = head_valid && out_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = head_valid;
  assign c_out     = head_q[WIDTH-1:0];
  assign z_out     = head_q[WIDTH];
  assign n_out     = head_q[WIDTH+1];
  assign v_out     = head_q[WIDTH+2];

`ifdef ALU_SKID_EN
  entry_t skid_q;
  logic   skid_full;

  // The only combinational term is flush. out_ready never reaches in_ready.
  assign in_ready = !skid_full && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q     <= '0;
      head_valid <= 1'b0;
      skid_q     <= '0;
      skid_full  <= 1'b0;
    end else if (flush) begin
      head_valid <= 1'b0;
      skid_full  <= 1'b0;
    end else if (consume) begin
      // accept implies !skid_full, so the skid entry and a new input
      // never compete for the head slot in the same cycle.
      if (skid_full) begin
        head_q    <= skid_q;
        skid_full <= 1'b0;
      end else if (accept) begin
        head_q <= new_entry;
      end else begin
        head_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!head_valid) begin
        head_q     <= new_entry;
        head_valid <= 1'b1;
      end else begin
        skid_q    <= new_entry;
        skid_full <= 1'b1;
      end
    end
  end
`else
  assign in_ready = (!head_valid || out_ready) && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q     <= '0;
      head_valid <= 1'b0;
    end else if (flush) begin
      head_valid <= 1'b0;
    end else if (accept) begin
      head_q     <= new_entry;
      head_valid <= 1'b1;
    end else if (consume) begin
      head_valid <= 1'b0;
    end
  end
`endif

  // A consume in the flush cycle still counts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ops_done <= '0;
    end else if (consume) begin
      ops_done <= ops_done + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_status_stage.sv
module tb_alu_status_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid, z_out, n_out, v_out;
  logic [15:0] ain, bin, c_out, ops_done;
  logic [1:0]  aluop;

  always #5 clk = ~clk;

  alu_status_stage #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .ain(ain), .bin(bin), .aluop(aluop),
    .out_valid(out_valid), .out_ready(out_ready),
    .c_out(c_out), .z_out(z_out), .n_out(n_out), .v_out(v_out),
    .ops_done(ops_done)
  );

`ifdef ALU_SKID_EN
  localparam int EXP_ACC = 2;
`else
  localparam int EXP_ACC = 1;
`endif

  typedef struct packed {
    logic [15:0] c;
    logic        z, n, v;
  } exp_t;

  exp_t        sb[$];
  exp_t        exp_next;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic        stalled = 1'b0;
  logic [18:0] held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  // Monitor / scoreboard: pops on every output handshake, pushes on every
  // accepted input, and checks that held results stay stable during a stall.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      stalled <= 1'b0;
    end else begin
      if (stalled && out_valid)
        check("stall_stable", {c_out, z_out, n_out, v_out}, held);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_output", out_valid, 1'b0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result", {c_out, z_out, n_out, v_out}, {e.c, e.z, e.n, e.v});
        end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(exp_next);
      stalled <= out_valid && !out_ready && !flush;
      held    <= {c_out, z_out, n_out, v_out};
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                      input logic [15:0] ec, input logic ez, input logic en, input logic ev);
    logic ok;
    ok = 1'b0;
    ain = a; bin = b; aluop = op;
    exp_next = '{c: ec, z: ez, n: en, v: ev};
    in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #2;
      if (!out_valid) return;
    end
    check("drain_timeout", out_valid, 1'b0);
  endtask

  task automatic set_vec(input int k);
    case (k)
      0: begin ain = 16'h0001; bin = 16'h0002; aluop = 2'b00; exp_next = '{c: 16'h0003, z: 0, n: 0, v: 0}; end
      1: begin ain = 16'h4000; bin = 16'h4000; aluop = 2'b00; exp_next = '{c: 16'h8000, z: 0, n: 1, v: 1}; end
      default: begin ain = 16'h0000; bin = 16'h0001; aluop = 2'b01; exp_next = '{c: 16'hFFFF, z: 0, n: 1, v: 0}; end
    endcase
  endtask

  // Holds out_ready low and offers vectors for a few cycles; returns accepts.
  task automatic stall_fill(output int acc);
    acc = 0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      set_vec(acc);
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int          acc, nstall, guard, i;
    logic [15:0] ops_snap, iv, ec;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ain = '0; bin = '0; aluop = '0; exp_next = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_flags_c", {c_out, z_out, n_out, v_out}, 19'h0);
    check("rst_ops_done", ops_done, 16'h0);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Directed arithmetic / logic vectors.
    out_ready = 1'b1;
    send(16'h7FFF, 16'h0001, 2'b00, 16'h8000, 0, 1, 1);
    wait_drain();
    check("ops_after_first", ops_done, 16'd1);
    send(16'h0005, 16'h0005, 2'b01, 16'h0000, 1, 0, 0);
    send(16'h1234, 16'h00FF, 2'b11, 16'hFF00, 0, 1, 0);
    send(16'hF0F0, 16'h0FF0, 2'b10, 16'h00F0, 0, 0, 0);
    send(16'h8000, 16'h0001, 2'b01, 16'h7FFF, 0, 0, 1);
    send(16'hFFFF, 16'h0001, 2'b00, 16'h0000, 1, 0, 0);
    wait_drain();
    check("ops_after_directed", ops_done, 16'd6);
    check("sb_empty_directed", sb.size(), 0);

    // Stall: count accepts while out_ready is low, then drain in order.
    stall_fill(acc);
    check("stall_accepts", acc, EXP_ACC);
    out_ready = 1'b1;
    wait_drain();
    check("ops_after_stall", ops_done, 16'(6 + EXP_ACC));
    check("sb_empty_stall", sb.size(), 0);

    // Long stream at full throughput; ops_done wraps.
    ops_snap = ops_done;
    nstall = 0; guard = 0; i = 0;
    out_ready = 1'b1;
    while (i < 70000 && guard < 80000) begin
      iv = i[15:0];
      if (i % 2 == 0) begin ain = iv; bin = 16'hFFFF; aluop = 2'b10; ec = iv; end
      else            begin ain = 16'h5555; bin = iv; aluop = 2'b11; ec = ~iv; end
      exp_next = '{c: ec, z: (ec == 16'h0), n: ec[15], v: 1'b0};
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) i++;
      else nstall++;
      guard++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_drain();
    check("stream_stalls", nstall, 0);
    check("stream_count", i, 70000);
    check("ops_wrap", ops_done, 16'(ops_snap + 16'(70000 % 65536)));

    // Flush with buffered entries and a simultaneous input.
    stall_fill(acc);
    check("flush_fill", out_valid, 1'b1);
    ops_snap = ops_done;
    set_vec(0);
    in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_out_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    check("flush_not_accepted", out_valid, 1'b0);
    check("flush_ops_done", ops_done, ops_snap);

    // Asynchronous reset during a stall.
    out_ready = 1'b0;
    send(16'h1111, 16'h2222, 2'b00, 16'h3333, 0, 0, 0);
    check("pre_reset_valid", out_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("async_out_valid", out_valid, 1'b0);
    check("async_flags_c", {c_out, z_out, n_out, v_out}, 19'h0);
    check("async_ops_done", ops_done, 16'h0);
    @(posedge clk); #1 reset = 1'b0;
    out_ready = 1'b1;
    send(16'h0003, 16'h0005, 2'b01, 16'hFFFE, 0, 1, 0);
    wait_drain();
    check("post_reset_ops", ops_done, 16'd1);
    check("sb_empty_end", sb.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
